bus_master_if: RTL and testbench
================================

BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset (clk, rst); no other clocks or resets.
REQ-002 TIMEOUT_CYCLES, 255: maximum WAIT_RSP cycles before forced completion (used only with BUS_TIMEOUT_EN).
REQ-003 ERR_RDATA, 32'hDEAD_BEEF: read data returned on error or timeout.
REQ-004 clk  in  1  pipeline clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 m_sel  in  1  memory-stage address is in bus space (address >= 512).
REQ-007 mem_read_M / mem_write_M  in  1 each  memory-stage load/store strobes.
REQ-008 addr_bus  in  32  memory-stage bus address.
REQ-009 wdata_M  in  32  store data; byte_en_M  in  4  store byte enables.
REQ-010 stall_bus  out  1  freeze IF..M stages while a bus access is outstanding.
REQ-011 rdata_bus_M  out  32  load result, valid in DONE.
REQ-012 bus_err  out  1  one-cycle error pulse in DONE.
REQ-013 bus_req_valid  out  1; bus_req_ready  in  1  request handshake.
REQ-014 bus_we  out  1; bus_addr  out  32; bus_wdata  out  32; bus_be  out  4  request payload.
REQ-015 bus_rsp_valid  in  1; bus_rsp_rdata  in  32; bus_rsp_err  in  1  response channel.

Function
REQ-016 SHALL implement four states: IDLE, REQ, WAIT_RSP, DONE.
REQ-017 Start = IDLE & m_sel & (mem_read_M | mem_write_M); on start, SHALL register addr, wdata, byte_en and we (= mem_write_M) and go to REQ.
REQ-018 If both read and write strobes are high, write SHALL take priority.
REQ-019 stall_bus SHALL equal start | (state==REQ) | (state==WAIT_RSP), combinationally; it SHALL be 0 in DONE.
REQ-020 In REQ, bus_req_valid=1 and the payload SHALL stay stable until bus_req_ready; on the ready cycle, go to WAIT_RSP.
REQ-021 bus_rsp_valid SHALL be ignored outside WAIT_RSP, including in the same cycle as the accepting bus_req_ready.
REQ-022 In WAIT_RSP, on bus_rsp_valid: capture bus_rsp_rdata (reads; ERR_RDATA if bus_rsp_err), latch err, go to DONE.
REQ-023 Writes SHALL also wait for bus_rsp_valid; rdata_bus_M SHALL hold 0 for writes.
REQ-024 DONE SHALL last exactly one cycle, with bus_err = latched err, and then return to IDLE; no start is evaluated in DONE.
REQ-025 Minimum latency SHALL be start -> REQ (ready=1) -> WAIT_RSP (rsp=1) -> DONE, giving 3 stalled cycles before DONE.
REQ-026 bus_req_valid, bus_we, bus_addr, bus_wdata and bus_be SHALL be registered outputs; the payload SHALL be 0 whenever valid=0.

Reset
REQ-027 On rst: state=IDLE; every registered output=0; timeout counter=0.
REQ-028 rst mid-transaction SHALL abandon the access; bus_req_valid SHALL be 0 the following cycle, and any late response SHALL be ignored.

Configuration
REQ-029 With BUS_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_RSP and increment each WAIT_RSP cycle.
REQ-030 With BUS_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without a response SHALL force DONE with bus_err=1 and rdata_bus_M=ERR_RDATA (reads).
REQ-031 Without BUS_TIMEOUT_EN, WAIT_RSP SHALL wait indefinitely, no counter is built, and bus_err comes only from bus_rsp_err.

Structure
REQ-032 Package bus_pkg SHALL hold the state enum typedef, the BUS_BASE=512 constant, and the defaults for TIMEOUT_CYCLES and ERR_RDATA.
REQ-033 The timeout counter SHALL be a sub-module, bus_timeout_cnt (ports: clk, rst, clr, en, expired), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-034 Load to 0x200, ready=1 immediately, rsp one cycle later with rdata 0x12345678 -> stall high 3 cycles; DONE shows rdata_bus_M=0x12345678, bus_err=0.
REQ-035 Store 0xCAFEF00D, be=4'b0011, to 0x204; ready held low 4 cycles -> payload stable all 4 cycles; bus_we=1; DONE rdata=0.
REQ-036 Load with bus_rsp_err=1 -> DONE with bus_err=1 and rdata_bus_M=0xDEADBEEF.
REQ-037 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> DONE after 8 WAIT_RSP cycles, bus_err=1; without the macro, still stalled after 100 cycles.
REQ-038 rst asserted in WAIT_RSP, then rsp_valid the next cycle -> IDLE, stall_bus=0, no DONE, no bus_err.
REQ-039 m_sel=0 with load, or m_sel=1 without a strobe -> no request issued and stall_bus=0.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the pipeline bus master interface.
//   bus_state_e        - transaction FSM state encoding
//   BUS_BASE           - first address that belongs to bus space
//   TIMEOUT_CYCLES_DEF - default response timeout (cycles in WAIT_RSP)
//   ERR_RDATA_DEF      - default read data returned on error/timeout
//   in_bus_space()     - address decode helper for bus space
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } bus_state_e;

  localparam logic [31:0] BUS_BASE           = 32'd512;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam logic [31:0] ERR_RDATA_DEF      = 32'hDEAD_BEEF;

  function automatic logic in_bus_space(input logic [31:0] addr);
    return addr >= BUS_BASE;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: counts cycles spent waiting for a bus response.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count from zero (entry into the wait state)
//   en       : one wait cycle elapses
//   expired  : high during the LIMIT-th enabled cycle since the last clear
module bus_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count holds (LIMIT-1) during the LIMIT-th wait cycle, so the FSM
  // leaves the wait state after exactly LIMIT cycles.
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/bus_master_if.sv
// bus_master_if: turns a memory-stage load/store that targets bus space into
// a single request/response bus transaction, freezing the pipeline meanwhile.
//
// Optional feature: define BUS_TIMEOUT_EN to force completion with an error
// after TIMEOUT_CYCLES cycles without a response. Without it the interface
// waits for a response indefinitely.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m_sel, mem_read_M, mem_write_M memory-stage bus select and strobes
//   addr_bus, wdata_M, byte_en_M   memory-stage address / store payload
//   stall_bus                     freeze IF..M while an access is in flight
//   rdata_bus_M, bus_err          load result and error pulse, valid in DONE
//   bus_req_valid/bus_req_ready   request handshake
//   bus_we/addr/wdata/be          registered request payload (0 when idle)
//   bus_rsp_valid/rdata/err       response channel
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no access; a selected load/store starts one
// ST_REQ      | request presented, payload held until bus_req_ready
// ST_WAIT_RSP | request accepted, waiting for bus_rsp_valid (or timeout)
// ST_DONE     | one cycle: result on rdata_bus_M/bus_err, pipeline released
module bus_master_if
  import bus_pkg::*;
#(
`ifdef BUS_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
`endif
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_sel,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [31:0] addr_bus,
  input  logic [31:0] wdata_M,
  input  logic [3:0]  byte_en_M,
  output logic        stall_bus,
  output logic [31:0] rdata_bus_M,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  bus_state_e  state_q, state_d;
  logic        req_valid_q, req_valid_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  // Direction of the access in flight; the bus payload is cleared once the
  // request is accepted, so this remembers whether the result is a load.
  logic        txn_we_q, txn_we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic start;
  logic timeout_hit;

  assign start = (state_q == ST_IDLE) && m_sel && (mem_read_M || mem_write_M);

`ifdef BUS_TIMEOUT_EN
  logic cnt_clr;
  logic cnt_en;

  assign cnt_clr = (state_q == ST_REQ) && bus_req_ready;
  assign cnt_en  = (state_q == ST_WAIT_RSP);

  bus_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    txn_we_d    = txn_we_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_REQ;
          req_valid_d = 1'b1;
          // A store wins when both strobes are set.
          we_d        = mem_write_M;
          txn_we_d    = mem_write_M;
          addr_d      = addr_bus;
          wdata_d     = wdata_M;
          be_d        = byte_en_M;
        end
      end
      ST_REQ: begin
        if (bus_req_ready) begin
          state_d     = ST_WAIT_RSP;
          req_valid_d = 1'b0;
          we_d        = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          be_d        = '0;
        end
      end
      ST_WAIT_RSP: begin
        // A real response takes precedence over a timeout in the same cycle.
        if (bus_rsp_valid) begin
          state_d = ST_DONE;
          err_d   = bus_rsp_err;
          if (txn_we_q) begin
            rdata_d = '0;
          end else if (bus_rsp_err) begin
            rdata_d = ERR_RDATA;
          end else begin
            rdata_d = bus_rsp_rdata;
          end
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = txn_we_q ? 32'd0 : ERR_RDATA;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        err_d    = 1'b0;
        rdata_d  = '0;
        txn_we_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      txn_we_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      txn_we_q    <= txn_we_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // The starting cycle stalls combinationally so the M stage does not
  // advance past the access before the FSM has registered it.
  assign stall_bus = start || (state_q == ST_REQ) || (state_q == ST_WAIT_RSP);

  assign bus_req_valid = req_valid_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_be        = be_q;
  assign rdata_bus_M   = rdata_q;
  assign bus_err       = err_q;

endmodule

// File: tb/tb_bus_master_if.sv
module tb_bus_master_if;
  import bus_pkg::*;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 0;
`endif

  logic        clk;
  logic        rst;
  logic        m_sel;
  logic        mem_read_M;
  logic        mem_write_M;
  logic [31:0] addr_bus;
  logic [31:0] wdata_M;
  logic [3:0]  byte_en_M;
  logic        stall_bus;
  logic [31:0] rdata_bus_M;
  logic        bus_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;

  bus_master_if #(
`ifdef BUS_TIMEOUT_EN
    .TIMEOUT_CYCLES(TO_CYC),
`endif
    .ERR_RDATA(ERR_RDATA_DEF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_sel        (m_sel),
    .mem_read_M   (mem_read_M),
    .mem_write_M  (mem_write_M),
    .addr_bus     (addr_bus),
    .wdata_M      (wdata_M),
    .byte_en_M    (byte_en_M),
    .stall_bus    (stall_bus),
    .rdata_bus_M  (rdata_bus_M),
    .bus_err      (bus_err),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_rdata(bus_rsp_rdata),
    .bus_rsp_err  (bus_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall_len;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t exp_req;
  rsp_t exp_rsp;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: a DONE cycle is the first unstalled cycle after a stalled run
  // that was not cut short by reset.
  logic prev_stall = 1'b0;
  logic prev_rst   = 1'b1;
  int   run        = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!prev_rst && prev_stall && !stall_bus) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: rdata %h err %b with no access outstanding", rdata_bus_M, bus_err);
        end else begin
          exp_rsp = rsp_q.pop_front();
          chk("done_rdata", rdata_bus_M, exp_rsp.rdata);
          chk("done_err", 32'(bus_err), 32'(exp_rsp.err));
          chk("stall_len", 32'(run), 32'(exp_rsp.stall_len));
        end
      end else begin
        chk("err_outside_done", 32'(bus_err), 32'd0);
      end

      if (bus_req_valid) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: addr %h we %b with no access expected", bus_addr, bus_we);
        end else begin
          exp_req = req_q[0];
          chk("req_we", 32'(bus_we), 32'(exp_req.we));
          chk("req_addr", bus_addr, exp_req.addr);
          chk("req_wdata", bus_wdata, exp_req.wdata);
          chk("req_be", 32'(bus_be), 32'(exp_req.be));
          if (bus_req_ready) void'(req_q.pop_front());
        end
      end else begin
        chk("idle_addr", bus_addr, 32'd0);
        chk("idle_wdata", bus_wdata, 32'd0);
        chk("idle_we_be", {27'd0, bus_we, bus_be}, 32'd0);
      end
    end
    if (stall_bus) run = run + 1;
    else run = 0;
    prev_stall = stall_bus;
    prev_rst   = rst;
  end

  task automatic clear_cpu();
    m_sel       = 1'b0;
    mem_read_M  = 1'b0;
    mem_write_M = 1'b0;
    addr_bus    = 32'($urandom);
    wdata_M     = 32'($urandom);
    byte_en_M   = 4'($urandom);
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic do_txn(input logic rd, input logic wr, input logic ms,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int rdly, input int sdly,
                        input logic rerr, input logic [31:0] rrdata,
                        input logic no_rsp, input logic done_poke);
    rsp_t r;
    int   waitc;
    m_sel       = ms;
    mem_read_M  = rd;
    mem_write_M = wr;
    addr_bus    = addr;
    wdata_M     = wdata;
    byte_en_M   = be;
    if (!(ms && (rd || wr))) begin
      @(negedge clk);
      chk("nostart_stall", 32'(stall_bus), 32'd0);
      @(posedge clk); #1;
      clear_cpu();
      @(negedge clk);
      chk("nostart_valid", 32'(bus_req_valid), 32'd0);
      @(posedge clk); #1;
      return;
    end

    req_q.push_back('{we: wr, addr: addr, wdata: wdata, be: be});
    if (no_rsp) begin
      waitc   = TO_CYC;
      r.err   = 1'b1;
      r.rdata = wr ? 32'd0 : ERR_RDATA_DEF;
    end else begin
      waitc   = sdly + 1;
      r.err   = rerr;
      r.rdata = wr ? 32'd0 : (rerr ? ERR_RDATA_DEF : rrdata);
    end
    // start cycle + REQ cycles + WAIT_RSP cycles
    r.stall_len = 1 + (rdly + 1) + waitc;
    rsp_q.push_back(r);

    @(posedge clk); #1;
    clear_cpu();
    repeat (rdly) begin
      bus_rsp_valid = 1'($urandom_range(1));
      bus_rsp_rdata = 32'($urandom);
      bus_rsp_err   = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'($urandom_range(1));
    bus_rsp_rdata = 32'($urandom);
    bus_rsp_err   = 1'($urandom_range(1));
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    if (no_rsp) begin
      repeat (waitc) begin @(posedge clk); #1; end
    end else begin
      repeat (sdly) begin @(posedge clk); #1; end
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = rrdata;
      bus_rsp_err   = rerr;
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      bus_rsp_rdata = 32'($urandom);
    end
    // DONE cycle: a fresh access presented here must not start yet.
    if (done_poke) begin
      m_sel      = 1'b1;
      mem_read_M = 1'b1;
    end
    @(posedge clk); #1;
    clear_cpu();
  endtask

  task automatic rst_in_wait();
    m_sel = 1'b1; mem_read_M = 1'b1; addr_bus = 32'h300; wdata_M = 32'h0; byte_en_M = 4'hF;
    req_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'hF});
    @(posedge clk); #1;
    clear_cpu();
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'h5555_AAAA;
    bus_rsp_err   = 1'b1;
    @(negedge clk);
    chk("rstwait_stall", 32'(stall_bus), 32'd0);
    chk("rstwait_err", 32'(bus_err), 32'd0);
    chk("rstwait_valid", 32'(bus_req_valid), 32'd0);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    @(negedge clk);
    chk("rstwait_stall2", 32'(stall_bus), 32'd0);
    chk("rstwait_err2", 32'(bus_err), 32'd0);
    chk("rstwait_rdata2", rdata_bus_M, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rst_in_req();
    m_sel = 1'b1; mem_write_M = 1'b1; addr_bus = 32'h400; wdata_M = 32'h1234_0000; byte_en_M = 4'hC;
    req_q.push_back('{we: 1'b1, addr: 32'h400, wdata: 32'h1234_0000, be: 4'hC});
    @(posedge clk); #1;
    clear_cpu();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(req_q.pop_back());
    @(negedge clk);
    chk("rstreq_valid", 32'(bus_req_valid), 32'd0);
    chk("rstreq_stall", 32'(stall_bus), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic        rd, wr, ms;
    logic [31:0] a;
    rst           = 1'b1;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 32'd0;
    bus_rsp_err   = 1'b0;
    clear_cpu();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(stall_bus), 32'd0);
    chk("reset_valid", 32'(bus_req_valid), 32'd0);
    chk("reset_rdata", rdata_bus_M, 32'd0);
    chk("reset_err", 32'(bus_err), 32'd0);
    chk("reset_addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // minimum-latency load
    do_txn(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 4'hF, 0, 0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    // store held off by the bus for 4 cycles
    do_txn(1'b0, 1'b1, 1'b1, 32'h204, 32'hCAFE_F00D, 4'b0011, 4, 0, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
    // load with an error response
    do_txn(1'b1, 1'b0, 1'b1, 32'h208, 32'h0, 4'hF, 1, 2, 1'b1, 32'h1111_1111, 1'b0, 1'b1);
    // both strobes: store wins
    do_txn(1'b1, 1'b1, 1'b1, 32'h20C, 32'h0BAD_F00D, 4'hF, 0, 1, 1'b0, 32'h7777_7777, 1'b0, 1'b0);
    // no access: unselected load, selected without strobe
    do_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    do_txn(1'b0, 1'b0, 1'b1, 32'h210, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef BUS_TIMEOUT_EN
    do_txn(1'b1, 1'b0, 1'b1, 32'h214, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    do_txn(1'b0, 1'b1, 1'b1, 32'h218, 32'h1, 4'h1, 2, 0, 1'b0, 32'h0, 1'b1, 1'b0);
`else
    // a slow responder: still stalled after 100 waiting cycles
    do_txn(1'b1, 1'b0, 1'b1, 32'h214, 32'h0, 4'hF, 0, 100, 1'b0, 32'hA5A5_5A5A, 1'b0, 1'b0);
`endif
    rst_in_wait();
    rst_in_req();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(9) == 0) begin
        if ($urandom_range(1) == 0) begin
          ms = 1'b0; rd = 1'b1; wr = 1'b0;
        end else begin
          ms = 1'b1; rd = 1'b0; wr = 1'b0;
        end
      end else begin
        ms = 1'b1;
        rd = 1'($urandom_range(1));
        wr = 1'($urandom_range(1));
        if (!rd && !wr) rd = 1'b1;
      end
      a = BUS_BASE + 32'($urandom_range(65535));
      if (ms && !in_bus_space(a)) a = BUS_BASE;
      do_txn(rd, wr, ms, a, 32'($urandom), 4'($urandom), $urandom_range(3), $urandom_range(4),
             1'($urandom_range(3) == 0), 32'($urandom), 1'b0, 1'($urandom_range(1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
